// File: rtl/btn_pkg.sv
// Shared definitions for the keypad decoder: key count, code width, code type.
package btn_pkg;

  localparam int unsigned NUM_KEYS   = 20;
  localparam int unsigned KEY_CODE_W = 5;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic key_code_t lowest_set(input logic [NUM_KEYS-1:0] v);
    key_code_t r;
    r = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (v[i]) r = key_code_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO with a registered head/valid view of the next entry.
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;

  assign o_full_c = (r_count == CNT_W'(DEPTH));
  assign o_data   = r_data;
  assign o_valid  = r_valid;

  // Accepted pop/push, next occupancy and the head value to present next cycle.
  always_comb begin
    w_pop       = i_pop && r_valid;
    w_push      = i_push && (!o_full_c || w_pop);
    w_rptr_nxt  = w_pop ? r_rptr + PTR_W'(1) : r_rptr;
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
    w_data_nxt = '0;
    if (w_count_nxt != '0) begin
      // The entry being written this cycle becomes the head: bypass the memory.
      if (w_push && (r_wptr == w_rptr_nxt)) w_data_nxt = i_data;
      else                                  w_data_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

endmodule

// File: rtl/btn_decode.sv
// Debounces the raw keypad scan vector and queues key-press codes over valid/ready.
module btn_decode
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned DB_DEPTH   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] btn_result,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                key_valid,
  output key_code_t           key_code,
  input  logic                key_ready,
  output logic                overflow
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]    r_div;
  logic [DB_DEPTH-1:0] r_hist [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_key_state;
  logic [NUM_KEYS-1:0] r_pend;
  logic                r_overflow;

  logic                w_tick;
  logic [DB_DEPTH-1:0] w_shift [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic                w_full_c;
  logic                w_pop;
  logic                w_push;
  key_code_t           w_push_code;
  logic [NUM_KEYS-1:0] w_push_mask;
  logic                w_ovf;

  assign w_tick    = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign key_state = r_key_state;
  assign overflow  = r_overflow;

  // Sample prescaler: counts 0..SAMPLE_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // Per-key shifted history and the press/release decisions for a tick.
  always_comb begin
    w_press   = '0;
    w_release = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      w_shift[i] = {r_hist[i][DB_DEPTH-2:0], btn_result[i]};
      if (w_tick) begin
        if ((&w_shift[i]) && !r_key_state[i]) w_press[i]   = 1'b1;
        if (w_shift[i] == '0)                 w_release[i] = 1'b1;
      end
    end
  end

  // Push the lowest pending key when the FIFO has room or is popping this cycle.
  always_comb begin
    w_pop       = key_valid && key_ready;
    w_push      = (r_pend != '0) && (!w_full_c || w_pop);
    w_push_code = lowest_set(r_pend);
    w_push_mask = w_push ? (NUM_KEYS'(1) << w_push_code) : '0;
    // A press on an already-pending key is lost, unless that key is leaving this cycle.
    w_ovf       = |(w_press & r_pend & ~w_push_mask);
  end

  // Debounce histories, debounced levels, pending mask and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) r_hist[i] <= '0;
      r_key_state <= '0;
      r_pend      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_tick) begin
        for (int i = 0; i < int'(NUM_KEYS); i++) r_hist[i] <= w_shift[i];
      end
      r_key_state <= (r_key_state | w_press) & ~w_release;
      r_pend      <= (r_pend & ~w_push_mask) | w_press;
      r_overflow  <= w_ovf;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_pop    (key_ready),
    .i_data   (w_push_code),
    .o_data   (key_code),
    .o_valid  (key_valid),
    .o_full_c (w_full_c)
  );

endmodule

// File: tb/tb_btn_decode.sv
// Directed bench for btn_decode with SAMPLE_DIV=8, DB_DEPTH=4, FIFO_DEPTH=4.
module tb_btn_decode;
  import btn_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_KEYS-1:0] btn_result = '0;
  logic [NUM_KEYS-1:0] key_state;
  logic                key_valid;
  key_code_t           key_code;
  logic                key_ready = 1'b0;
  logic                overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  btn_decode #(
    .SAMPLE_DIV (8),
    .DB_DEPTH   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_result (btn_result),
    .key_state  (key_state),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; cyc counts edges since reset release, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(key_state), 32'h0);
    chk({tag, "_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_code"},  32'(key_code),  32'h0);
    chk({tag, "_ovf"},   32'(overflow),  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Reset with arbitrary scan input
    btn_result = 20'($urandom());
    #3;
    do_reset("rst");

    // Single press of key 7
    btn_result = '0;
    btn_result[7] = 1'b1;
    key_ready = 1'b1;
    step_to(31);
    chk("sp_state_pre", 32'(key_state), 32'h0);
    step();
    chk("sp_state", 32'(key_state), 32'h80);
    chk("sp_valid_t", 32'(key_valid), 32'h0);
    step();
    chk("sp_valid", 32'(key_valid), 32'h1);
    chk("sp_code", 32'(key_code), 32'd7);
    step();
    chk("sp_valid_once", 32'(key_valid), 32'h0);
    viol = 0;
    while (cyc < 48) begin
      step();
      if (key_valid || overflow) viol++;
    end
    btn_result[7] = 1'b0;
    while (cyc < 79) begin
      step();
      if (key_valid || overflow) viol++;
    end
    chk("sp_rel_pre", 32'(key_state), 32'h80);
    step();
    chk("sp_rel", 32'(key_state), 32'h0);
    while (cyc < 90) begin
      step();
      if (key_valid || overflow) viol++;
    end
    chk("sp_no_repeat", 32'(viol), 32'h0);

    // Bounce on key 3, toggled every tick for 12 ticks
    do_reset("rst_b");
    btn_result = '0;
    btn_result[3] = 1'b1;
    viol = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (key_state[3] || key_valid) viol++;
      if ((c % 8 == 0) && (c <= 96)) btn_result[3] = ~btn_result[3];
    end
    btn_result = '0;
    chk("bounce", 32'(viol), 32'h0);

    // Simultaneous press of keys 15, 2, 9
    do_reset("rst_s");
    btn_result = '0;
    btn_result[15] = 1'b1;
    btn_result[2]  = 1'b1;
    btn_result[9]  = 1'b1;
    key_ready = 1'b1;
    step_to(32);
    chk("sim_state", 32'(key_state), 32'h0_8204);
    step();
    chk("sim_v0", 32'(key_valid), 32'h1);
    chk("sim_c0", 32'(key_code), 32'd2);
    step();
    chk("sim_v1", 32'(key_valid), 32'h1);
    chk("sim_c1", 32'(key_code), 32'd9);
    step();
    chk("sim_v2", 32'(key_valid), 32'h1);
    chk("sim_c2", 32'(key_code), 32'd15);
    step();
    chk("sim_end", 32'(key_valid), 32'h0);

    // Backpressure: keys 0..5 pressed one tick apart, consumer stalled
    do_reset("rst_bp");
    btn_result = '0;
    key_ready = 1'b0;
    btn_result[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step_to(8 * k);
      btn_result[k] = 1'b1;
    end
    step_to(73);
    chk("bp_state", 32'(key_state), 32'h3F);
    chk("bp_valid", 32'(key_valid), 32'h1);
    chk("bp_head", 32'(key_code), 32'd0);
    step_to(80);
    btn_result[4] = 1'b0;
    step_to(111);
    chk("bp_rel_pre", 32'(key_state), 32'h3F);
    step();
    chk("bp_rel", 32'(key_state), 32'h2F);
    btn_result[4] = 1'b1;
    viol = 0;
    while (cyc < 143) begin
      step();
      if (overflow) viol++;
    end
    chk("bp_no_early_ovf", 32'(viol), 32'h0);
    step();
    chk("bp_ovf", 32'(overflow), 32'h1);
    chk("bp_repress", 32'(key_state), 32'h3F);
    step();
    chk("bp_ovf_pulse", 32'(overflow), 32'h0);
    key_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      chk($sformatf("bp_v%0d", i), 32'(key_valid), 32'h1);
      chk($sformatf("bp_c%0d", i), 32'(key_code), 32'(i));
      step();
    end
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      if (key_valid || overflow) viol++;
      step();
    end
    chk("bp_drained", 32'(viol), 32'h0);

    // Reset while a code is visible and more are pending
    do_reset("rst_m0");
    btn_result = '0;
    btn_result[15] = 1'b1;
    btn_result[2]  = 1'b1;
    btn_result[9]  = 1'b1;
    key_ready = 1'b0;
    step_to(33);
    chk("mid_valid", 32'(key_valid), 32'h1);
    chk("mid_code", 32'(key_code), 32'd2);
    btn_result = '0;
    key_ready = 1'b1;
    do_reset("mid_rst");
    viol = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (key_valid || overflow || (key_state != '0)) viol++;
    end
    chk("mid_no_stale", 32'(viol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
